t03_sprite_compositor: RTL

//  Parametrised VGA display pipeline: timing generator plus NUM_SPR sprite layers composited over a background colour.

---
 rtl/t03_dpu_pkg.sv | 29 ++
 rtl/t03_vga_timing.sv | 62 ++++++
 rtl/t03_sprite_compositor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/t03_dpu_pkg.sv
// Shared display-pipeline types and constants.
// VGA 640x480 timing defaults, RGB332 colour type, sprite helpers.
package t03_dpu_pkg;

  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_ACT  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t KEY_COLOR = 8'hE3;

  // A layer claims the pixel only when hit and not transparent.
  function automatic logic opaque(
    input logic    hit,
    input rgb332_t data,
    input rgb332_t key
  );
    return hit && (data != key);
  endfunction

endpackage

// File: rtl/t03_vga_timing.sv
// Raster counters with raw sync, active window and frame markers.
// Sync/active are combinational from the current counter position.
module t03_vga_timing #(
  parameter int CW     = 11,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          active,
  output logic          frame_end,
  output logic          frame_start
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACT + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACT + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACT + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACT + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_AE   = CW'(H_ACT);
  localparam logic [CW-1:0] V_AE   = CW'(V_ACT);

  logic h_wrap;

  assign h_wrap = (hcnt == H_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign hsync_raw   = !(hcnt >= H_SS && hcnt < H_SE);
  assign vsync_raw   = !(vcnt >= V_SS && vcnt < V_SE);
  assign active      = (hcnt < H_AE) && (vcnt < V_AE);
  assign frame_end   = h_wrap && (vcnt == V_LAST);
  assign frame_start = pix_en && frame_end;

endmodule

// File: rtl/t03_sprite_compositor.sv
// VGA pipeline: timing, double-buffered sprite layers, priority mux.
// Colour and sync leave two pix_en ticks after their raster position.
module t03_sprite_compositor #(
  parameter int NUM_SPR = 2,
  parameter int SPR_W   = 40,
  parameter int SPR_H   = 60,
  parameter int CW      = 11,
  parameter int AW      = 12,
  parameter int H_ACT   = t03_dpu_pkg::H_ACT,
  parameter int H_FP    = t03_dpu_pkg::H_FP,
  parameter int H_SYNC  = t03_dpu_pkg::H_SYNC,
  parameter int H_BP    = t03_dpu_pkg::H_BP,
  parameter int V_ACT   = t03_dpu_pkg::V_ACT,
  parameter int V_FP    = t03_dpu_pkg::V_FP,
  parameter int V_SYNC  = t03_dpu_pkg::V_SYNC,
  parameter int V_BP    = t03_dpu_pkg::V_BP,
  parameter logic [7:0] KEY_COLOR = t03_dpu_pkg::KEY_COLOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  input  logic [7:0]            bg_color,
  input  logic [NUM_SPR*CW-1:0] spr_x,
  input  logic [NUM_SPR*CW-1:0] spr_y,
  input  logic [NUM_SPR-1:0]    spr_en,
  input  logic [NUM_SPR-1:0]    spr_flip,
  output logic [NUM_SPR*AW-1:0] spr_rom_addr,
  input  logic [NUM_SPR*8-1:0]  spr_rom_data,
  output logic                  hsync,
  output logic                  vsync,
  output logic [7:0]            color,
  output logic                  frame_start
);

  import t03_dpu_pkg::*;

  localparam logic [CW:0]   W_LIM = (CW+1)'(SPR_W);
  localparam logic [CW:0]   H_LIM = (CW+1)'(SPR_H);
  localparam logic [AW-1:0] W_AW  = AW'(SPR_W);
  localparam logic [AW-1:0] W_MAX = AW'(SPR_W - 1);

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          hs_raw;
  logic          vs_raw;
  logic          active;
  logic          frame_end;

  t03_vga_timing #(
    .CW(CW),
    .H_ACT(H_ACT), .H_FP(H_FP),
    .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en),
    .hcnt(hcnt),
    .vcnt(vcnt),
    .hsync_raw(hs_raw),
    .vsync_raw(vs_raw),
    .active(active),
    .frame_end(frame_end),
    .frame_start(frame_start)
  );

  logic [CW-1:0]      sh_x [NUM_SPR];
  logic [CW-1:0]      sh_y [NUM_SPR];
  logic [NUM_SPR-1:0] sh_en;
  logic [NUM_SPR-1:0] sh_flip;

  // Shadows only move on the last pixel, so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
      end
      sh_en   <= '0;
      sh_flip <= '0;
    end else if (pix_en && frame_end) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        sh_x[i] <= spr_x[i*CW +: CW];
        sh_y[i] <= spr_y[i*CW +: CW];
      end
      sh_en   <= spr_en;
      sh_flip <= spr_flip;
    end
  end

  logic [NUM_SPR-1:0] hit_q;

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    logic [CW:0]   dx;
    logic [CW:0]   dy;
    logic          hit;
    logic [AW-1:0] col;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_q;
    logic          hq;

    // One extra bit makes left/above positions large, hence misses.
    assign dx  = {1'b0, hcnt} - {1'b0, sh_x[g]};
    assign dy  = {1'b0, vcnt} - {1'b0, sh_y[g]};
    assign hit = sh_en[g] && (dx < W_LIM) && (dy < H_LIM);
    assign col = sh_flip[g] ? W_MAX - AW'(dx) : AW'(dx);
    assign addr = AW'(dy) * W_AW + col;

    always_ff @(posedge clk) begin
      if (rst) begin
        hq     <= 1'b0;
        addr_q <= '0;
      end else if (pix_en) begin
        hq     <= hit;
        addr_q <= hit ? addr : '0;
      end
    end

    assign hit_q[g] = hq;
    assign spr_rom_addr[g*AW +: AW] = addr_q;
  end

  logic act_q;
  logic hs_q;
  logic vs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_en) begin
      act_q <= active;
      hs_q  <= hs_raw;
      vs_q  <= vs_raw;
    end
  end

  rgb332_t pix;

  // Walk from lowest priority up so sprite 0 has the final word.
  always_comb begin
    pix = bg_color;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (opaque(hit_q[i], spr_rom_data[i*8 +: 8], KEY_COLOR))
        pix = spr_rom_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      color <= 8'h00;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      color <= act_q ? pix : 8'h00;
      hsync <= hs_q;
      vsync <= vs_q;
    end
  end

endmodule
